as_mod6: RTL and testbench

//  3-bit asynchronous (ripple) mod-6 up-counter built from three T flip-flop stages.

---
 rtl/as_mod6.sv | 36 +++
 tb/tb_as_mod6.sv | 96 +++++++++
 2 files changed

// File: rtl/as_mod6.sv
// as_mod6: ripple mod-6 up-counter built from three T flip-flops with a combinational clear at 110.
module as_mod6_tff (
  input  logic t,
  input  logic clk,
  input  logic clr,
  output logic q,
  output logic qbar
);
  always_ff @(posedge clk or negedge clr)
    if (!clr) q <= 1'b0;
    else if (t) q <= ~q;
  assign qbar = ~q;
endmodule

module as_mod6 (
  input  logic [2:0] t,
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] q,
  output logic [2:0] qbar
);
  logic       clr;
  logic [2:0] sclk;
  assign clr = rst & ~(q[2] & q[1]);
  // Ripple clocks are held high while clear is asserted, so a clear-induced fall never counts as an edge.
  assign sclk = {qbar[1] | ~clr, qbar[0] | ~clr, clk};
  for (genvar i = 0; i < 3; i++) begin : g_stage
    as_mod6_tff u_tff (
      .t   (t[i]),
      .clk (sclk[i]),
      .clr (clr),
      .q   (q[i]),
      .qbar(qbar[i])
    );
  end
endmodule

// File: tb/tb_as_mod6.sv
// tb_as_mod6: directed and random checks of as_mod6 against a per-stage toggle model.
module tb_as_mod6;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] t = 3'b000;
  logic [2:0] q, qbar;
  logic [2:0] m = 3'b000;
  int n = 0;
  int errs = 0;

  as_mod6 dut (.t(t), .clk(clk), .rst(rst), .q(q), .qbar(qbar));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [2:0] exp);
    logic [2:0] expb;
    expb = ~exp;
    n++;
    assert (q === exp && qbar === expb)
    else begin
      errs++;
      $error("FAIL %s: q=%b qbar=%b expected q=%b qbar=%b", tag, q, qbar, exp, expb);
    end
  endtask

  // Each stage toggles on its predecessor's 1->0 transition when enabled; value 6 collapses to 0.
  function automatic logic [2:0] nxt(input logic [2:0] c, input logic [2:0] tv);
    logic [2:0] r;
    r = c;
    r[0] = c[0] ^ tv[0];
    if (c[0] && !r[0] && tv[1]) r[1] = ~c[1];
    if (c[1] && !r[1] && tv[2]) r[2] = ~c[2];
    return (r == 3'd6) ? 3'd0 : r;
  endfunction

  task automatic step(input logic [2:0] tv, input string tag);
    t = tv;
    @(posedge clk);
    m = nxt(m, tv);
    @(negedge clk);
    chk(tag, m);
  endtask

  task automatic arst(input string tag);
    #2 rst = 1'b0;
    #1 chk(tag, 3'd0);
    m = 3'd0;
    #1 rst = 1'b1;
  endtask

  initial begin
    repeat (3) begin
      @(negedge clk);
      chk("reset_hold", 3'd0);
    end
    rst = 1'b1;
    repeat (5) step(3'b000, "idle_t000");
    for (int k = 0; k < 12; k++) begin
      step(3'b111, "count_model");
      chk("count_mod6", 3'((k + 1) % 6));
    end
    repeat (4) step(3'b111, "to_100");
    chk("at_100", 3'b100);
    repeat (4) step(3'b000, "hold_100");
    chk("held_100", 3'b100);
    step(3'b111, "resume_101");
    chk("resume_101_abs", 3'b101);
    step(3'b111, "wrap_000");
    chk("wrap_000_abs", 3'b000);
    repeat (3) step(3'b111, "to_011");
    chk("at_011", 3'b011);
    arst("async_rst_mid");
    step(3'b111, "after_rst_001");
    chk("after_rst_001_abs", 3'b001);
    @(negedge clk);
    arst("rst_for_mod4");
    for (int k = 0; k < 8; k++) begin
      step(3'b011, "mod4_model");
      chk("mod4_abs", 3'((k + 1) % 4));
    end
    for (int k = 0; k < 4; k++) begin
      step(3'b001, "lsb_model");
      chk("lsb_abs", 3'((k + 1) % 2));
    end
    arst("rst_for_run");
    repeat (12) step(3'b111, "run12");
    chk("run12_back_000", 3'd0);
    arst("rerst");
    for (int k = 0; k < 250; k++) begin
      if ($urandom_range(0, 15) == 0) arst("rand_rst");
      else step(3'($urandom_range(0, 7)), "rand_step");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n, errs);
    $finish;
  end
endmodule
